// File: rtl/icache_assoc_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
// Holds the refill FSM encoding and the way-index width helper.
package icache_assoc_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_DRAIN
  } state_e;

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state for the instruction cache.
// Heap-ordered tree bits; each bit points toward the colder half.
import icache_assoc_pkg::*;

module icache_plru #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [IDX_W-1:0] vic_idx_i,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [WAY_W-1:0] upd_way_i,
  output logic [WAY_W-1:0] victim_o
);

  if (WAYS == 1) begin : g_direct
    assign victim_o = '0;
  end else begin : g_tree
    localparam int NODES = WAYS - 1;
    localparam int LVLS  = $clog2(WAYS);

    logic [SETS-1:0][NODES-1:0] tree_q;
    logic [NODES-1:0]           upd_bits;
    logic [NODES-1:0]           vic_bits;
    logic [WAY_W-1:0]           vic;

    // Touch only the nodes on the used way's path.
    always_comb begin
      upd_bits = tree_q[upd_idx_i];
      for (int l = 0; l < LVLS; l++) begin
        for (int p = 0; p < (1 << l); p++) begin
          if ((int'(upd_way_i) >> (LVLS - l)) == p)
            upd_bits[(1 << l) - 1 + p] = ~upd_way_i[LVLS-1-l];
        end
      end
    end

    always_comb begin
      vic_bits = tree_q[vic_idx_i];
      vic      = '0;
      for (int l = 0; l < LVLS; l++) begin
        for (int p = 0; p < (1 << l); p++) begin
          if ((int'(vic) >> (LVLS - l)) == p)
            vic[LVLS-1-l] = vic_bits[(1 << l) - 1 + p];
        end
      end
    end

    assign victim_o = vic;

    always_ff @(posedge clk) begin
      if (rst_in) begin
        tree_q <= '0;
      end else if (upd_i) begin
        tree_q[upd_idx_i] <= upd_bits;
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: same-cycle hit path to IF,
// single-outstanding block refill from memory with tree-PLRU victims.
import icache_assoc_pkg::*;

module icache_assoc #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int BLK_INSTR = 16
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic                      flush_in,
  input  logic                      if_req_in,
  input  logic [ADDR_W-1:0]         if_ain,
  output logic                      if_instr_out_en,
  output logic [INSTR_W-1:0]        if_instr_out,
  output logic                      mem_req_en,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_in_en,
  input  logic [ADDR_W-1:0]         mem_ain,
  input  logic [BLK_INSTR*32-1:0]   mem_din
);

  localparam int OFF_W   = $clog2(BLK_INSTR);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W - 2;
  localparam int BLK_W   = BLK_INSTR * 32;
  localparam int WAY_W   = way_w(WAYS);
  localparam int TAG_LSB = IDX_W + OFF_W + 2;
  localparam int BLK_LSB = OFF_W + 2;

  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
  logic [BLK_W-1:0]          data_q [WAYS][SETS];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;

  logic [TAG_W-1:0]    if_tag;
  logic [IDX_W-1:0]    if_idx;
  logic [OFF_W-1:0]    if_off;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic                hit;
  logic [BLK_W-1:0]    hit_line;

  logic [TAG_W-1:0]    r_tag;
  logic [IDX_W-1:0]    r_idx;
  logic                ret_match;
  logic [WAY_W-1:0]    plru_vic;
  logic [WAY_W-1:0]    victim;
  logic                fill;

  assign if_tag = if_ain[ADDR_W-1:TAG_LSB];
  assign if_idx = if_ain[TAG_LSB-1:BLK_LSB];
  assign if_off = if_ain[BLK_LSB-1:2];

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][if_idx] && tag_q[w][if_idx] == if_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit      = if_req_in & hit_any & ~flush_in;
  assign hit_line = data_q[hit_way][if_idx];

  assign if_instr_out_en = hit;
  assign if_instr_out    = hit ? hit_line[{if_off, 5'b0} +: 32] : '0;

  assign r_tag     = req_addr_q[ADDR_W-1:TAG_LSB];
  assign r_idx     = req_addr_q[TAG_LSB-1:BLK_LSB];
  assign ret_match = mem_in_en &&
                     mem_ain[ADDR_W-1:BLK_LSB] == req_addr_q[ADDR_W-1:BLK_LSB];

  // Empty ways fill first; PLRU only arbitrates a full set.
  always_comb begin
    victim = plru_vic;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][r_idx]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fill       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (if_req_in && !hit_any && !flush_in) begin
          req_addr_d = {if_ain[ADDR_W-1:BLK_LSB], {BLK_LSB{1'b0}}};
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        if (flush_in) begin
          state_d = ret_match ? S_IDLE : S_DRAIN;
        end else if (ret_match) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (ret_match) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_en   = (state_q != S_IDLE);
  assign mem_req_addr = req_addr_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in || flush_in) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[victim][r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim][r_idx]  <= r_tag;
      data_q[victim][r_idx] <= mem_din;
    end
  end

  icache_plru #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_plru (
    .clk       (clk),
    .rst_in    (rst_in),
    .vic_idx_i (r_idx),
    .upd_i     (fill | hit),
    .upd_idx_i (fill ? r_idx : if_idx),
    .upd_way_i (fill ? victim : hit_way),
    .victim_o  (plru_vic)
  );

  logic unused_bits;
  assign unused_bits = ^{if_ain[1:0], mem_ain[BLK_LSB-1:0]};

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: lookup table plus refill,
// flush, stray-return and reset corner sequences.
module tb_icache_assoc;

  localparam int BLK_W = 16 * 32;

  logic             clk = 1'b0;
  logic             rst_in;
  logic             flush_in;
  logic             if_req_in;
  logic [31:0]      if_ain;
  logic             if_instr_out_en;
  logic [31:0]      if_instr_out;
  logic             mem_req_en;
  logic [31:0]      mem_req_addr;
  logic             mem_in_en;
  logic [31:0]      mem_ain;
  logic [BLK_W-1:0] mem_din;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  icache_assoc #(
    .WAYS      (2),
    .SETS      (16),
    .BLK_INSTR (16)
  ) dut (
    .clk             (clk),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .if_req_in       (if_req_in),
    .if_ain          (if_ain),
    .if_instr_out_en (if_instr_out_en),
    .if_instr_out    (if_instr_out),
    .mem_req_en      (mem_req_en),
    .mem_req_addr    (mem_req_addr),
    .mem_in_en       (mem_in_en),
    .mem_ain         (mem_ain),
    .mem_din         (mem_din)
  );

  typedef struct {
    logic [31:0] addr;
    logic        hit;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h0000_0013;
    return 32'hC000_0000 | {a[31:2], 2'b00};
  endfunction

  function automatic logic [BLK_W-1:0] mkblk(input logic [31:0] base);
    logic [BLK_W-1:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = word_at(base + 32'(k * 4));
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic ret(input logic [31:0] a, input logic fl);
    mem_in_en = 1'b1;
    mem_ain   = a;
    mem_din   = mkblk(a);
    flush_in  = fl;
    @(posedge clk); #1;
    mem_in_en = 1'b0;
    flush_in  = 1'b0;
  endtask

  task automatic serve(input logic [31:0] base);
    chk($sformatf("req_en@%h", base), {31'd0, mem_req_en}, 32'd1);
    chk($sformatf("req_addr@%h", base), mem_req_addr, base);
    ret(base, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] a, input logic exp_hit,
                        input logic srv);
    if_req_in = 1'b1;
    if_ain    = a;
    @(negedge clk);
    chk($sformatf("hit@%h", a), {31'd0, if_instr_out_en}, {31'd0, exp_hit});
    chk($sformatf("instr@%h", a), if_instr_out,
        exp_hit ? word_at(a) : 32'd0);
    @(posedge clk); #1;
    if_req_in = 1'b0;
    if (!exp_hit && srv) serve({a[31:6], 6'd0});
  endtask

  initial begin
    tbl[0]  = '{32'h400, 1'b0};
    tbl[1]  = '{32'h000, 1'b1};
    tbl[2]  = '{32'h800, 1'b0};
    tbl[3]  = '{32'h000, 1'b1};
    tbl[4]  = '{32'h400, 1'b0};
    tbl[5]  = '{32'h03C, 1'b1};
    tbl[6]  = '{32'h040, 1'b0};
    tbl[7]  = '{32'h044, 1'b1};
    tbl[8]  = '{32'h800, 1'b0};
    tbl[9]  = '{32'h004, 1'b1};
    tbl[10] = '{32'h400, 1'b0};

    rst_in    = 1'b1;
    flush_in  = 1'b0;
    if_req_in = 1'b0;
    if_ain    = '0;
    mem_in_en = 1'b0;
    mem_ain   = '0;
    mem_din   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    chk("rst_en", {31'd0, if_instr_out_en}, 32'd0);
    chk("rst_instr", if_instr_out, 32'd0);
    chk("rst_req_en", {31'd0, mem_req_en}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);

    // First miss, request, fill, then hit.
    lookup(32'h000, 1'b0, 1'b0);
    chk("t1_req_en", {31'd0, mem_req_en}, 32'd1);
    chk("t1_req_addr", mem_req_addr, 32'h000);
    ret(32'h000, 1'b0);
    lookup(32'h000, 1'b1, 1'b0);

    // PLRU eviction and offset selection.
    for (int i = 0; i < 11; i++) lookup(tbl[i].addr, tbl[i].hit, 1'b1);

    // Stray return, then flush during refill.
    lookup(32'h100, 1'b0, 1'b0);
    chk("t4_req_en", {31'd0, mem_req_en}, 32'd1);
    chk("t4_req_addr", mem_req_addr, 32'h100);
    ret(32'h200, 1'b0);
    chk("t5_req_en", {31'd0, mem_req_en}, 32'd1);
    chk("t5_req_addr", mem_req_addr, 32'h100);
    lookup(32'h200, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 1'b0);
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("drain_req_en", {31'd0, mem_req_en}, 32'd1);
    chk("drain_req_addr", mem_req_addr, 32'h100);
    lookup(32'h000, 1'b0, 1'b0);
    lookup(32'h03C, 1'b0, 1'b0);
    ret(32'h100, 1'b0);
    chk("drain_done", {31'd0, mem_req_en}, 32'd0);
    lookup(32'h100, 1'b0, 1'b1);
    lookup(32'h100, 1'b1, 1'b0);
    lookup(32'h000, 1'b0, 1'b1);
    lookup(32'h004, 1'b1, 1'b0);

    // Flush and return in the same cycle: flush wins.
    lookup(32'h180, 1'b0, 1'b0);
    ret(32'h180, 1'b1);
    chk("simul_req_en", {31'd0, mem_req_en}, 32'd0);
    lookup(32'h180, 1'b0, 1'b1);
    flush_in = 1'b1;
    lookup(32'h180, 1'b0, 1'b0);
    flush_in = 1'b0;
    chk("flush_no_req", {31'd0, mem_req_en}, 32'd0);

    // Reset mid-refill, then a late return.
    lookup(32'h2C0, 1'b0, 1'b0);
    chk("t6_req_en", {31'd0, mem_req_en}, 32'd1);
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    chk("t6_rst_req_en", {31'd0, mem_req_en}, 32'd0);
    chk("t6_rst_req_addr", mem_req_addr, 32'd0);
    ret(32'h2C0, 1'b0);
    chk("t6_late_req_en", {31'd0, mem_req_en}, 32'd0);
    lookup(32'h2C0, 1'b0, 1'b0);
    chk("t6_new_req_addr", mem_req_addr, 32'h2C0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
